uart_rx_buf: RTL and testbench

Receive-side byte buffer between the UART receive deserializer and the Wishbone UART front end. It captures every byte the deserializer completes and holds it in a small show-ahead FIFO. Bus reads can then pop bytes without blocking on the serial line. It reports fill level and a sticky overflow flag for software polling.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_buf_byte_fifo.sv | 51 +++++
 rtl/uart_rx_buf.sv | 64 ++++++
 tb/tb_uart_rx_buf.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and a constant-function clog2 for the receive path.
package uart_pkg;
  localparam int UART_BYTE_W   = 8;
  localparam int UART_RX_DEPTH = 8;
  localparam int UART_RX_WMARK = 4;

  function automatic int uart_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_buf_byte_fifo.sv
// Generic show-ahead FIFO core; a push into a full FIFO is accepted only
// when the head pops in the same cycle, otherwise it is reported as a drop.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int W     = UART_BYTE_W,
  localparam int AW   = uart_clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          drop
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push, pop;

  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign out_data  = mem[rd_ptr];

  // Storage is intentionally not reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_buf.sv
// UART receive byte buffer: FIFO core plus sticky overflow flag.
// Define UART_RX_BUF_WMARK_EN to build the registered watermark interrupt irq_o.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int WMARK = UART_RX_WMARK,
  localparam int AW   = uart_clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] in_data,
  input  logic                   in_valid,
  output logic [UART_BYTE_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   irq_o
);
  logic drop, ovf_nxt;

  byte_fifo #(.DEPTH(DEPTH), .W(UART_BYTE_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .drop      (drop)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  assign ovf_nxt = drop | (overflow & ~ovf_clr);

  always_ff @(posedge clk)
    if (rst) overflow <= 1'b0;
    else     overflow <= ovf_nxt;

`ifdef UART_RX_BUF_WMARK_EN
  logic        pop, push;
  logic [AW:0] cnt_nxt;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);

  always_comb begin
    cnt_nxt = count;
    if (push & ~pop)      cnt_nxt = count + 1'b1;
    else if (pop & ~push) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk)
    if (rst) irq_o <= 1'b0;
    else     irq_o <= (cnt_nxt >= (AW+1)'(WMARK)) | ovf_nxt;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: directed cases then random traffic vs a queue model.
module tb_uart_rx_buf;
  localparam int DEPTH = 8;
  localparam int WMARK = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, ovf_clr;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       out_valid, full, overflow, irq_o;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_irq;

  always #5 clk = ~clk;

  uart_rx_buf #(.DEPTH(DEPTH), .WMARK(WMARK)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow), .ovf_clr(ovf_clr),
    .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model built from the FIFO rules: queue of bytes, sticky flag, watermark.
  task automatic model_step(input logic r, input logic iv, input logic [7:0] d,
                            input logic rdy, input logic clr);
    bit was_full, pop, drop;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_irq = 1'b0;
      return;
    end
    was_full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && rdy;
    drop = iv && was_full && !pop;
    if (pop) void'(q.pop_front());
    if (iv && !drop) q.push_back(d);
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
`ifdef UART_RX_BUF_WMARK_EN
    m_irq = (q.size() >= WMARK) || m_ovf;
`else
    m_irq = 1'b0;
`endif
  endtask

  task automatic compare_all();
    chk("count",     32'(count),     32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("irq_o",     32'(irq_o),     32'(m_irq));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] d,
                     input logic rdy, input logic clr);
    rst = r; in_valid = iv; in_data = d; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_step(r, iv, d, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0; m_irq = 1'b0;
    @(negedge clk);

    // Reset with in_valid asserted must be ignored.
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // Single byte in, then out.
    push(8'hA5);
    chk("single_data", 32'(out_data), 32'h0A5);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", 32'(out_valid), 32'd0);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    push(8'hFF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(out_data), 32'h00);
    drain();

    // Drop together with clear keeps the flag; clear alone releases it.
    for (int i = 0; i < DEPTH; i++) push(8'h30 + 8'(i));
    cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with concurrent pop: accepted, no overflow.
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Wrap-around with mixed concurrent push/pop.
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b1, 8'h10 + 8'(i), (i % 3) == 2, 1'b0);
    drain();

    // Reset mid-operation discards contents.
    push(8'h01); push(8'h02);
    cyc(1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
    chk("midrst_count", 32'(count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
          8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
